// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc
//   Hazard controller for the five-stage RISC-V pipeline. It forwards
//   operands from M/W into Execute, inserts load-use bubbles, holds Execute
//   while a multi-cycle MUL/DIV runs, and freezes the pipe while data memory
//   is not ready.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   rs1D, rs2D                   Decode source registers
//   rs1E, rs2E, rdE              Execute sources / destination
//   rdM, rdW                     Memory / Writeback destinations
//   reg_writeM, reg_writeW       register-write enables in M / W
//   result_selE                  instruction in E is a load
//   mdu_startE                   instruction in E is MUL/DIV
//   pc_sel                       taken branch/jump resolved in E
//   dmem_stallM                  data memory not ready this cycle
//   forwardAE, forwardBE         00 regfile, 01 from W, 10 from M
//   stallF/D/E/M                 hold stage register
//   flushD/E/M/W                 bubble into stage register
//   mdu_busy                     MDU sequence in BUSY or DONE
module hazard_ctrl_mc #(
    parameter int REG_AW       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MDU_LAT      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              reg_writeM,
    input  logic              reg_writeW,
    input  logic              result_selE,
    input  logic              mdu_startE,
    input  logic              pc_sel,
    input  logic              dmem_stallM,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              mdu_busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mdu_state_t;

    localparam logic [1:0] LD_INIT   = 2'(LOAD_BUBBLES - 1);
    localparam logic [4:0] MDU_INIT  = 5'(MDU_LAT - 2);
    localparam bit         MDU_MULTI = (MDU_LAT > 1);
    localparam bit         MDU_LONG  = (MDU_LAT > 2);

    mdu_state_t r_state, w_state_nxt;
    logic [1:0] r_ld_cnt, w_ld_cnt_nxt;
    logic [4:0] r_mdu_cnt, w_mdu_cnt_nxt;

    logic w_lw_hit, w_ld_start, w_ld_stall, w_mdu_stall;

    // Forwarding: M has priority over W; x0 is never forwarded.
    always_comb begin
        forwardAE = 2'b00;
        if (reg_writeM && rs1E != '0 && rs1E == rdM)
            forwardAE = 2'b10;
        else if (reg_writeW && rs1E != '0 && rs1E == rdW)
            forwardAE = 2'b01;

        forwardBE = 2'b00;
        if (reg_writeM && rs2E != '0 && rs2E == rdM)
            forwardBE = 2'b10;
        else if (reg_writeW && rs2E != '0 && rs2E == rdW)
            forwardBE = 2'b01;
    end

    always_comb begin
        w_lw_hit    = result_selE && (rdE != '0) && ((rs1D == rdE) || (rs2D == rdE));
        // A new bubble sequence only starts when idle; a redirect discards it.
        w_ld_start  = w_lw_hit && (r_ld_cnt == '0) && (r_state == S_IDLE) && !pc_sel;
        w_ld_stall  = w_ld_start || (r_ld_cnt != '0);
        w_mdu_stall = (r_state == S_IDLE && mdu_startE && MDU_MULTI) || (r_state == S_BUSY);

        w_state_nxt   = r_state;
        w_ld_cnt_nxt  = r_ld_cnt;
        w_mdu_cnt_nxt = r_mdu_cnt;

        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        stallM   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        flushM   = 1'b0;
        flushW   = 1'b0;
        mdu_busy = (r_state != S_IDLE);

        if (rst) begin
            flushD   = 1'b1;
            flushE   = 1'b1;
            flushM   = 1'b1;
            flushW   = 1'b1;
            mdu_busy = 1'b0;
        end else if (dmem_stallM) begin
            // Whole-pipe freeze: all sequencing state holds.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else begin
            stallF = w_mdu_stall || (w_ld_stall && !pc_sel);
            stallD = w_mdu_stall || (w_ld_stall && !pc_sel);
            stallE = w_mdu_stall;
            flushM = w_mdu_stall;
            flushD = pc_sel;
            flushE = pc_sel || w_ld_stall;

            if (pc_sel)
                w_ld_cnt_nxt = '0;
            else if (w_ld_start)
                w_ld_cnt_nxt = LD_INIT;
            else if (r_ld_cnt != '0)
                w_ld_cnt_nxt = r_ld_cnt - 2'd1;

            case (r_state)
                S_IDLE: begin
                    if (mdu_startE && MDU_MULTI) begin
                        w_mdu_cnt_nxt = MDU_INIT;
                        w_state_nxt   = MDU_LONG ? S_BUSY : S_DONE;
                    end
                end
                S_BUSY: begin
                    w_mdu_cnt_nxt = r_mdu_cnt - 5'd1;
                    if (r_mdu_cnt == 5'd1)
                        w_state_nxt = S_DONE;
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ld_cnt  <= '0;
            r_mdu_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ld_cnt  <= w_ld_cnt_nxt;
            r_mdu_cnt <= w_mdu_cnt_nxt;
        end
    end

endmodule
